native_port_arbiter: RTL

- Parametrised N-port arbiter for the native (litedram user-port) protocol. Multiplexes NPORTS native user ports onto one native master port toward the crossbar/controller.
- Grant is round-robin, one command at a time.
- A single data beat follows every write command.
- Read data is routed back to the issuing port in order, through a port-index order FIFO.
- Generalises the fixed single-port native bundle to a configurable port count, with read-return tracking.

---
 rtl/native_port_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/native_port_arbiter.sv
// Port-index order FIFO remembering which user port issued each outstanding read.
// Latency: head visible the cycle after push; backpressure: push ignored when full, pop ignored when empty.
module npa_order_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic [AW:0]   count,
  output logic          full
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign push   = wr_vld && !full;
  assign pop    = rd_rdy && (count != '0);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end
endmodule

// Round-robin NPORTS:1 arbiter for native user ports; read beats return to issuers in order.
// Latency: request to m_cmd_valid 1 cycle; backpressure: master readies pass to the granted/head port, reads stall while the order FIFO is full.
module native_port_arbiter #(
  parameter int NPORTS   = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 256,
  parameter int MASK_W   = DATA_W/8,
  parameter int RD_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        s_cmd_valid,
  output logic [NPORTS-1:0]        s_cmd_ready,
  input  logic [NPORTS-1:0]        s_cmd_we,
  input  logic [NPORTS*ADDR_W-1:0] s_cmd_addr,
  input  logic [NPORTS-1:0]        s_wdata_valid,
  output logic [NPORTS-1:0]        s_wdata_ready,
  input  logic [NPORTS*DATA_W-1:0] s_wdata_data,
  input  logic [NPORTS*MASK_W-1:0] s_wdata_we,
  output logic [NPORTS-1:0]        s_rdata_valid,
  input  logic [NPORTS-1:0]        s_rdata_ready,
  output logic [DATA_W-1:0]        s_rdata_data,
  output logic                     m_cmd_valid,
  input  logic                     m_cmd_ready,
  output logic                     m_cmd_we,
  output logic [ADDR_W-1:0]        m_cmd_addr,
  output logic                     m_wdata_valid,
  input  logic                     m_wdata_ready,
  output logic [DATA_W-1:0]        m_wdata_data,
  output logic [MASK_W-1:0]        m_wdata_we,
  input  logic                     m_rdata_valid,
  output logic                     m_rdata_ready,
  input  logic [DATA_W-1:0]        m_rdata_data
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(RD_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;

  state_t            fsm;
  logic [PW-1:0]     gnt;
  logic [PW-1:0]     rr_last;
  logic [NPORTS-1:0] elig;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     pick;
  logic              pick_vld;
  logic              rd_push;
  logic              rd_pop;
  logic [PW-1:0]     head;
  logic [CW-1:0]     rd_count;
  logic              rd_full;

  // Scan from the far end so the last hit is the first port after rr_last.
  always_comb begin
    elig     = s_cmd_valid & (s_cmd_we | {NPORTS{~rd_full}});
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      cand = PW'((int'(rr_last) + k) % NPORTS);
      if (elig[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm     <= IDLE;
      gnt     <= '0;
      rr_last <= PW'(NPORTS - 1);
    end else begin
      case (fsm)
        IDLE: begin
          if (pick_vld) begin
            gnt     <= pick;
            rr_last <= pick;
            fsm     <= CMD;
          end
        end
        CMD: begin
          if (m_cmd_valid && m_cmd_ready) fsm <= m_cmd_we ? WDATA : IDLE;
        end
        WDATA: begin
          if (m_wdata_valid && m_wdata_ready) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Every valid/ready is also qualified by rst so nothing leaks out while reset is held.
  always_comb begin
    m_cmd_valid   = 1'b0;
    m_cmd_we      = s_cmd_we[gnt];
    m_cmd_addr    = s_cmd_addr[int'(gnt)*ADDR_W +: ADDR_W];
    s_cmd_ready   = '0;
    m_wdata_valid = 1'b0;
    m_wdata_data  = s_wdata_data[int'(gnt)*DATA_W +: DATA_W];
    m_wdata_we    = s_wdata_we[int'(gnt)*MASK_W +: MASK_W];
    s_wdata_ready = '0;
    if (rst && fsm == CMD) begin
      m_cmd_valid      = s_cmd_valid[gnt];
      s_cmd_ready[gnt] = m_cmd_ready;
    end
    if (rst && fsm == WDATA) begin
      m_wdata_valid      = s_wdata_valid[gnt];
      s_wdata_ready[gnt] = m_wdata_ready;
    end
  end

  assign rd_push = m_cmd_valid && m_cmd_ready && !m_cmd_we;
  assign rd_pop  = m_rdata_valid && m_rdata_ready;

  npa_order_fifo #(.W(PW), .DEPTH(RD_DEPTH)) u_order (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (rd_push),
    .wr_dat (gnt),
    .rd_rdy (rd_pop),
    .rd_dat (head),
    .count  (rd_count),
    .full   (rd_full)
  );

  // With nothing outstanding a master beat has no owner, so it is held off rather than dropped.
  always_comb begin
    s_rdata_valid = '0;
    m_rdata_ready = 1'b0;
    if (rst && rd_count != '0) begin
      s_rdata_valid[head] = m_rdata_valid;
      m_rdata_ready       = s_rdata_ready[head];
    end
  end

  assign s_rdata_data = m_rdata_data;
endmodule
